// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to InstructionMemory,
// and registers the returned word into the IF/ID pipeline register.
//
// Handshake semantics (single comment covering every control input):
//   - redirect_valid is a one-cycle pulse sampled at the rising edge.
//     It reloads the PC with a word-aligned target and flushes IF/ID.
//   - stall is a level.
//     While it is high in RUN, the PC, IF/ID and fetch_count all hold.
//   - if_id_valid qualifies if_id_* for decode.
//     Decode consumes IF/ID on every edge where it does not raise stall.
//   - Priority per edge: btn_reset > redirect_valid > (BOOT) > stall > normal.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        btn_reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    input  logic [31:0] imem_instruction,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction,
    output logic [31:0] fetch_count,
    output logic        dbg_state
);

    // BOOT lasts exactly one cycle after reset so that the first PC is
    // presented to memory before anything is captured into IF/ID.
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc4_q;
    logic [31:0] if_instr_q;
    logic [31:0] count_q;

    // Next-PC candidates.
    // Masking the redirect target silently drops the low two bits.
    // Both increments wrap modulo 2^32 naturally.
    logic [31:0] pc_plus4_d;
    logic [31:0] target_d;
    logic [31:0] count_inc_d;

    // Next-PC, target and counter arithmetic.
    always_comb begin
        pc_plus4_d  = pc_q + 32'd4;
        target_d    = redirect_pc & 32'hFFFF_FFFC;
        count_inc_d = count_q + 32'd1;
    end

    // FSM with PC, IF/ID register and retired-fetch counter.
    always_ff @(posedge clk) begin
        if (btn_reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= 32'd0;
            if_pc4_q   <= 32'd4;
            if_instr_q <= NOP_INSTR;
            count_q    <= 32'd0;
        end else if (redirect_valid) begin
            // Redirect beats stall and BOOT.
            // if_id_pc and if_id_pc_plus4 keep their old values across the flush.
            state_q    <= ST_RUN;
            pc_q       <= target_d;
            valid_q    <= 1'b0;
            if_instr_q <= NOP_INSTR;
        end else if (state_q == ST_BOOT) begin
            // Stall is ignored here; PC simply stays at RESET_PC for this cycle.
            state_q <= ST_RUN;
        end else if (stall) begin
            // Hold everything for as long as decode asks.
            state_q <= ST_RUN;
        end else begin
            state_q    <= ST_RUN;
            if_pc_q    <= pc_q;
            if_pc4_q   <= pc_plus4_d;
            if_instr_q <= imem_instruction;
            valid_q    <= 1'b1;
            pc_q       <= pc_plus4_d;
            count_q    <= count_inc_d;
        end
    end

    assign pc                = pc_q;
    assign if_id_valid       = valid_q;
    assign if_id_pc          = if_pc_q;
    assign if_id_pc_plus4    = if_pc4_q;
    assign if_id_instruction = if_instr_q;
    assign fetch_count       = count_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
module tb_fetch_stage;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        btn_reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] pc;
    logic [31:0] imem_instruction;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic [31:0] fetch_count;
    logic        dbg_state;

    always #5 clk = ~clk;

    // Memory model: word at address A is A | 0xA000_0000.
    assign imem_instruction = pc | 32'hA000_0000;

    fetch_stage dut (
        .clk               (clk),
        .btn_reset         (btn_reset),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pc                (pc),
        .imem_instruction  (imem_instruction),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction),
        .fetch_count       (fetch_count),
        .dbg_state         (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ifpc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        st;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic [31:0] p, input logic v, input logic [31:0] ip,
                                input logic [31:0] p4, input logic [31:0] ins,
                                input logic [31:0] c, input logic st);
        vec_t r;
        r.stall = s; r.rv = rv; r.rpc = rpc; r.pc = p; r.valid = v; r.ifpc = ip;
        r.pc4 = p4; r.instr = ins; r.cnt = c; r.st = st;
        return r;
    endfunction

    // Check every output against one expected record.
    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".pc"},    pc,                e.pc);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        chk({tag, ".ifpc"},  if_id_pc,          e.ifpc);
        chk({tag, ".pc4"},   if_id_pc_plus4,    e.pc4);
        chk({tag, ".instr"}, if_id_instruction, e.instr);
        chk({tag, ".cnt"},   fetch_count,       e.cnt);
        chk({tag, ".state"}, {31'd0, dbg_state}, {31'd0, e.st});
    endtask

    // ---------------- driver ----------------
    // Drive inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic rst, input logic s, input logic rv, input logic [31:0] rpc);
        btn_reset = rst; stall = s; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    vec_t rst_exp;
    vec_t vec [0:19];
    vec_t e;

    initial begin
        rst_exp = mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h4, NOP, 0, 0);

        //           stall rv  rpc           pc            v  ifpc          pc4           instr          cnt st
        vec[0]  = mk(0,    0,  0,            32'h0,        0, 32'h0,        32'h4,        NOP,           0, 1); // BOOT edge
        vec[1]  = mk(0,    0,  0,            32'h4,        1, 32'h0,        32'h4,        32'hA000_0000, 1, 1);
        vec[2]  = mk(0,    0,  0,            32'h8,        1, 32'h4,        32'h8,        32'hA000_0004, 2, 1);
        vec[3]  = mk(1,    0,  0,            32'h8,        1, 32'h4,        32'h8,        32'hA000_0004, 2, 1);
        vec[4]  = mk(1,    0,  0,            32'h8,        1, 32'h4,        32'h8,        32'hA000_0004, 2, 1);
        vec[5]  = mk(1,    0,  0,            32'h8,        1, 32'h4,        32'h8,        32'hA000_0004, 2, 1);
        vec[6]  = mk(0,    0,  0,            32'hC,        1, 32'h8,        32'hC,        32'hA000_0008, 3, 1);
        vec[7]  = mk(0,    0,  0,            32'h10,       1, 32'hC,        32'h10,       32'hA000_000C, 4, 1);
        vec[8]  = mk(0,    1,  32'h40,       32'h40,       0, 32'hC,        32'h10,       NOP,           4, 1);
        vec[9]  = mk(0,    0,  0,            32'h44,       1, 32'h40,       32'h44,       32'hA000_0040, 5, 1);
        vec[10] = mk(1,    1,  32'h103,      32'h100,      0, 32'h40,       32'h44,       NOP,           5, 1);
        vec[11] = mk(1,    0,  0,            32'h100,      0, 32'h40,       32'h44,       NOP,           5, 1);
        vec[12] = mk(0,    0,  0,            32'h104,      1, 32'h100,      32'h104,      32'hA000_0100, 6, 1);
        vec[13] = mk(0,    1,  32'h200,      32'h200,      0, 32'h100,      32'h104,      NOP,           6, 1);
        vec[14] = mk(0,    1,  32'h302,      32'h300,      0, 32'h100,      32'h104,      NOP,           6, 1);
        vec[15] = mk(0,    0,  0,            32'h304,      1, 32'h300,      32'h304,      32'hA000_0300, 7, 1);
        vec[16] = mk(0,    1,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h300,    32'h304,      NOP,           7, 1);
        vec[17] = mk(0,    0,  0,            32'h0,        1, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 8, 1);
        vec[18] = mk(0,    0,  0,            32'h4,        1, 32'h0,        32'h4,        32'hA000_0000, 9, 1);
        vec[19] = mk(1,    0,  0,            32'h4,        1, 32'h0,        32'h4,        32'hA000_0000, 9, 1);

        // Reset for two edges, then check the reset state.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_all("reset", rst_exp);

        for (int i = 0; i < 20; i++) begin
            step(0, vec[i].stall, vec[i].rv, vec[i].rpc);
            chk_all($sformatf("v%0d", i), vec[i]);
        end

        // Reset while stalled with valid IF/ID: reset wins.
        step(1, 1, 0, 0);
        chk_all("rst_stall", rst_exp);
        // BOOT ignores stall; IF/ID still invalid.
        step(0, 1, 0, 0);
        chk_all("boot_stall", mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h4, NOP, 0, 1));
        step(0, 0, 0, 0);
        chk_all("boot_after", mk(0, 0, 0, 32'h4, 1, 32'h0, 32'h4, 32'hA000_0000, 1, 1));

        // Reset together with a redirect: reset wins.
        step(1, 0, 1, 32'h500);
        chk_all("rst_redir", rst_exp);
        // Redirect during BOOT is honoured and moves to RUN.
        step(0, 1, 1, 32'h81);
        chk_all("boot_redir", mk(0, 0, 0, 32'h80, 0, 32'h0, 32'h4, NOP, 0, 1));
        step(0, 0, 0, 0);
        e = mk(0, 0, 0, 32'h84, 1, 32'h80, 32'h84, 32'hA000_0080, 1, 1);
        chk_all("boot_redir2", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
